// File: rtl/stall_flush_ctrl.sv
// stall_flush_ctrl: stall/flush controller for the 5-stage RISC-V pipeline.
// Resolves load-use hazards, taken-branch redirects and variable-latency
// data-memory accesses. Memory accesses use a request/acknowledge handshake
// and are guarded by a watchdog that gives up after TIMEOUT un-acked cycles.
// Optional feature: define STALL_PERF_EN to add the saturating stall_cnt
// and flush_cnt performance counters.
module stall_flush_ctrl #(
   parameter int TIMEOUT = 15,
   parameter int PERF_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        rs1_D,
   input  logic [4:0]        rs2_D,
   input  logic [4:0]        RD_E,
   input  logic              MemRead_E,
   input  logic              PCSrcE,
   input  logic              MemReadM,
   input  logic              MemWriteM,
   input  logic              mem_ack,
   output logic              mem_req,
   output logic              StallF,
   output logic              StallD,
   output logic              StallE,
   output logic              StallM,
   output logic              FlushD,
   output logic              FlushE,
   output logic              FlushW,
   output logic              mem_err
`ifdef STALL_PERF_EN
   ,
   output logic [PERF_W-1:0] stall_cnt,
   output logic [PERF_W-1:0] flush_cnt
`endif
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] timeout_val = CW'(TIMEOUT);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] WAIT = 1'b1;

   logic [0:0]    state_reg, state_next;
   logic [CW-1:0] wait_cnt_reg, wait_cnt_next;
   logic          acc, lu, mem_stall;

   assign acc = MemReadM | MemWriteM;
   assign lu  = MemRead_E && (RD_E != 5'd0) && ((RD_E == rs1_D) || (RD_E == rs2_D));

   // Handshake FSM, watchdog and stall/flush priority (memory > branch > load-use).
   always_comb begin
      state_next    = state_reg;
      wait_cnt_next = wait_cnt_reg;
      mem_stall     = 1'b0;
      mem_req       = 1'b0;
      mem_err       = 1'b0;
      StallF        = 1'b0;
      StallD        = 1'b0;
      StallE        = 1'b0;
      StallM        = 1'b0;
      FlushD        = 1'b0;
      FlushE        = 1'b0;
      FlushW        = 1'b0;
      // Reset forces every output low, including mid-WAIT (no error pulse).
      if (rst) begin
         case (state_reg)
            IDLE: begin
               mem_req = acc;
               if (acc && !mem_ack) begin
                  mem_stall     = 1'b1;
                  wait_cnt_next = CW'(1);
                  state_next    = WAIT;
               end
            end
            WAIT: begin
               if (mem_ack) begin
                  mem_req       = 1'b1;
                  wait_cnt_next = '0;
                  state_next    = IDLE;
               end else if (wait_cnt_reg < timeout_val) begin
                  mem_req       = 1'b1;
                  mem_stall     = 1'b1;
                  wait_cnt_next = wait_cnt_reg + CW'(1);
               end else begin
                  // Watchdog abort: drop the request and release the pipeline.
                  mem_err       = 1'b1;
                  wait_cnt_next = '0;
                  state_next    = IDLE;
               end
            end
            default: begin
               wait_cnt_next = '0;
               state_next    = IDLE;
            end
         endcase

         if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
         end else if (PCSrcE) begin
            // A redirect discards the dependent instruction, so no load-use stall.
            FlushD = 1'b1;
            FlushE = 1'b1;
         end else if (lu) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
         end
      end
   end

   // FSM state and watchdog counter registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg    <= IDLE;
         wait_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
      end
   end

`ifdef STALL_PERF_EN
   logic [PERF_W-1:0] stall_cnt_reg, flush_cnt_reg;

   // Saturating counters of fetch-stall cycles and Execute-bubble cycles.
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cnt_reg <= '0;
         flush_cnt_reg <= '0;
      end else begin
         if (StallF && (stall_cnt_reg != {PERF_W{1'b1}}))
            stall_cnt_reg <= stall_cnt_reg + PERF_W'(1);
         if (FlushE && (flush_cnt_reg != {PERF_W{1'b1}}))
            flush_cnt_reg <= flush_cnt_reg + PERF_W'(1);
      end
   end

   assign stall_cnt = stall_cnt_reg;
   assign flush_cnt = flush_cnt_reg;
`endif

endmodule
